// File: rtl/pipe_pack_arbiter_pkg.sv
// Shared types and constants for the two-requester byte packer.
package pipe_pack_arbiter_pkg;

    localparam int NBYTES     = 3;
    localparam int DEFAULT_DW = 8;

    // Value of the byte counter when the last byte of a word is being captured.
    localparam logic [1:0] CNT_LAST = 2'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COLLECT = 2'b01,
        S_FULL    = 2'b10
    } state_t;

    // Round-robin pick: the requester after last_grant wins unless it is idle.
    // Only meaningful when at least one req bit is high.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        logic pri;
        pri = ~last_grant;
        return req[pri] ? pri : ~pri;
    endfunction

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pipe_pack_arbiter_if.sv
// Requester/consumer bundle for the packer: two byte requesters in, packed word out.
interface pipe_pack_arbiter_if
    import pipe_pack_arbiter_pkg::*;
#(
    parameter int DW = DEFAULT_DW
);

    logic [1:0]           req;
    logic [DW-1:0]        data0;
    logic [DW-1:0]        data1;
    logic [1:0]           gnt;
    logic [NBYTES*DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_src;

    // Requester/consumer side of the bundle.
    modport master (
        output req, data0, data1, out_ready,
        input  gnt, out_data, out_valid, out_src
    );

    // Arbiter side of the bundle.
    modport slave (
        input  req, data0, data1, out_ready,
        output gnt, out_data, out_valid, out_src
    );

endinterface

// File: rtl/pipe_pack_datapath.sv
// Byte shift packer. P2 takes the newest byte, so after three captures the
// first byte sits in P0 (low bits) and the last in P2 (high bits). P0..P2 are
// themselves the output word register: nothing shifts while a finished word
// waits for the consumer, so the word stays stable without a second copy.
module pipe_pack_datapath
    import pipe_pack_arbiter_pkg::*;
#(
    parameter int DW = DEFAULT_DW
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [DW-1:0]        byte_in,
    output logic [NBYTES*DW-1:0] word
);

    logic [DW-1:0] p0;
    logic [DW-1:0] p1;
    logic [DW-1:0] p2;

    // Shift a captured byte in, or wipe the packer on reset / word consumption.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
        end else if (shift_en) begin
            p2 <= byte_in;
            p1 <= p2;
            p0 <= p1;
        end
    end

    assign word = {p2, p1, p0};

endmodule

// File: rtl/pipe_pack_arbiter.sv
// Round-robin arbiter that packs three bytes from the granted requester into
// one output word, with stall support and output backpressure.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | no grant outstanding, waiting for any req
//   S_COLLECT | one requester granted, capturing bytes while its req is high
//   S_FULL    | word complete, out_valid high until out_ready
module pipe_pack_arbiter
    import pipe_pack_arbiter_pkg::*;
#(
    parameter int DW = DEFAULT_DW
)
(
    input logic               clk,
    input logic               rst,
    pipe_pack_arbiter_if.slave bus
);

    state_t     state_q;
    logic [1:0] gnt_q;
    logic [1:0] count_q;
    logic       valid_q;
    logic       src_q;
    logic       last_q;

    logic                 gnt_idx;
    logic                 capture;
    logic                 consume;
    logic                 winner;
    logic [DW-1:0]        byte_sel;
    logic [NBYTES*DW-1:0] word;

    // Grant decode, byte mux and handshake qualifiers for this cycle.
    always_comb begin
        gnt_idx  = gnt_q[1];
        byte_sel = gnt_q[1] ? bus.data1 : bus.data0;
        capture  = (state_q == S_COLLECT) && (|(gnt_q & bus.req));
        consume  = (state_q == S_FULL) && bus.out_ready;
        winner   = rr_pick(bus.req, last_q);
    end

    // Sequencer: grant, count captures, present the word, hand over on consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (|bus.req) begin
                        state_q <= S_COLLECT;
                        gnt_q   <= onehot(winner);
                        count_q <= '0;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                S_COLLECT: begin
                    if (capture) begin
                        if (count_q == CNT_LAST) begin
                            state_q <= S_FULL;
                            gnt_q   <= '0;
                            count_q <= '0;
                            valid_q <= 1'b1;
                            src_q   <= gnt_idx;
                            last_q  <= gnt_idx;
                        end else begin
                            count_q <= count_q + 2'd1;
                        end
                    end
                end
                S_FULL: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        if (|bus.req) begin
                            state_q <= S_COLLECT;
                            gnt_q   <= onehot(winner);
                            count_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    count_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    pipe_pack_datapath #(.DW(DW)) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .clear    (consume),
        .shift_en (capture),
        .byte_in  (byte_sel),
        .word     (word)
    );

    assign bus.gnt       = gnt_q;
    assign bus.out_valid = valid_q;
    assign bus.out_src   = src_q;
    assign bus.out_data  = word;

endmodule

// File: tb/tb_pipe_pack_arbiter.sv
// Directed bench for pipe_pack_arbiter: single packet, contention, stall,
// backpressure and reset in the middle of a word.
module tb_pipe_pack_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    pipe_pack_arbiter_if #(.DW(8)) bus ();

    pipe_pack_arbiter #(.DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = 2'b00;
        bus.data0     = 8'h00;
        bus.data1     = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_gnt",   32'(bus.gnt),       32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_data",  32'(bus.out_data),  32'h0);
        chk("rst_src",   32'(bus.out_src),   32'h0);

        // Single packet from requester 0
        rst           = 1'b0;
        bus.req       = 2'b01;
        bus.data0     = 8'hA1;
        bus.out_ready = 1'b1;
        tick();
        chk("single_gnt", 32'(bus.gnt), 32'h1);
        tick();
        bus.data0 = 8'hB2;
        tick();
        chk("single_not_early", 32'(bus.out_valid), 32'h0);
        bus.data0 = 8'hC3;
        tick();
        chk("single_valid",    32'(bus.out_valid), 32'h1);
        chk("single_data",     32'(bus.out_data),  32'hC3B2A1);
        chk("single_src",      32'(bus.out_src),   32'h0);
        chk("single_gnt_full", 32'(bus.gnt),       32'h0);
        bus.req = 2'b00;
        tick();
        chk("single_consumed", 32'(bus.out_valid), 32'h0);
        chk("single_idle_gnt", 32'(bus.gnt),       32'h0);

        // Contention right after reset: 0 first, then alternate
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        bus.req   = 2'b11;
        bus.data0 = 8'h5A;
        bus.data1 = 8'hA5;
        tick();
        chk("cont_gnt0", 32'(bus.gnt), 32'h1);
        tick();
        tick();
        tick();
        chk("cont_w0_valid", 32'(bus.out_valid), 32'h1);
        chk("cont_w0_src",   32'(bus.out_src),   32'h0);
        chk("cont_w0_data",  32'(bus.out_data),  32'h5A5A5A);
        tick();
        chk("cont_gnt1",  32'(bus.gnt),       32'h2);
        chk("cont_b2b",   32'(bus.out_valid), 32'h0);
        tick();
        tick();
        tick();
        chk("cont_w1_src",  32'(bus.out_src),  32'h1);
        chk("cont_w1_data", 32'(bus.out_data), 32'hA5A5A5);
        tick();
        chk("cont_gnt2", 32'(bus.gnt), 32'h1);
        tick();
        tick();
        tick();
        chk("cont_w2_valid", 32'(bus.out_valid), 32'h1);
        chk("cont_w2_src",   32'(bus.out_src),   32'h0);
        bus.req = 2'b00;
        tick();
        chk("cont_idle_valid", 32'(bus.out_valid), 32'h0);
        chk("cont_idle_gnt",   32'(bus.gnt),       32'h0);

        // Stall: requester 0 drops req for two cycles, requester 1 must not preempt
        bus.req       = 2'b01;
        bus.data0     = 8'hA1;
        bus.out_ready = 1'b0;
        tick();
        chk("stall_gnt", 32'(bus.gnt), 32'h1);
        tick();
        bus.req   = 2'b10;
        bus.data0 = 8'hFF;
        bus.data1 = 8'hEE;
        tick();
        chk("stall_hold1", 32'(bus.gnt), 32'h1);
        tick();
        chk("stall_hold2", 32'(bus.gnt),       32'h1);
        chk("stall_valid", 32'(bus.out_valid), 32'h0);
        bus.req   = 2'b01;
        bus.data0 = 8'hB2;
        tick();
        bus.data0 = 8'hC3;
        tick();
        chk("stall_valid6", 32'(bus.out_valid), 32'h1);
        chk("stall_data",   32'(bus.out_data),  32'hC3B2A1);

        // Backpressure: word held for five more cycles, req ignored meanwhile
        bus.req = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_data",  32'(bus.out_data),  32'hC3B2A1);
            chk("bp_gnt",   32'(bus.gnt),       32'h0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_consumed", 32'(bus.out_valid), 32'h0);
        chk("bp_next_gnt", 32'(bus.gnt),       32'h2);

        // Reset after two bytes from requester 1
        bus.req   = 2'b10;
        bus.data1 = 8'h44;
        tick();
        bus.data1 = 8'h55;
        tick();
        rst     = 1'b1;
        bus.req = 2'b11;
        tick();
        chk("mid_rst_gnt",   32'(bus.gnt),       32'h0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_data",  32'(bus.out_data),  32'h0);
        chk("mid_rst_src",   32'(bus.out_src),   32'h0);
        tick();
        chk("rst_ignores_req", 32'(bus.gnt), 32'h0);
        rst       = 1'b0;
        bus.req   = 2'b01;
        bus.data0 = 8'h11;
        tick();
        chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
        tick();
        bus.data0 = 8'h22;
        tick();
        bus.data0 = 8'h33;
        tick();
        chk("post_rst_valid", 32'(bus.out_valid), 32'h1);
        chk("post_rst_data",  32'(bus.out_data),  32'h332211);
        chk("post_rst_src",   32'(bus.out_src),   32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
